// File: rtl/execute_stage.sv
// Execute / write-back stage in front of the 8x8 register file with its CB bit.
// Single-cycle ALU ops, an iterative shift-add multiply, a registered
// write-back stage, and forwarding of that stage back into the operands.
module execute_stage #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [3:0]        op_i,
  input  logic              cond_i,
  input  logic [ADDR_W-1:0] dst_addr_i,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  input  logic [DATA_W-1:0] imm_i,
  output logic [ADDR_W-1:0] rs_addr_o,
  output logic [ADDR_W-1:0] rt_addr_o,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic              cb_data_i,
  output logic              write_o,
  output logic [ADDR_W-1:0] write_addr_o,
  output logic [DATA_W-1:0] write_data_o,
  output logic              write_CB_o,
  output logic              cb_data_o
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
    OP_OR  = 4'h4, OP_XOR = 4'h5, OP_SHL = 4'h6, OP_SHR = 4'h7,
    OP_MOV = 4'h8, OP_LDI = 4'h9, OP_SEQ = 4'hA, OP_SLT = 4'hB,
    OP_MUL = 4'hC
  } op_e;

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] rs_eff, rt_eff;
  logic              cb_eff, accept, exec;
  logic [DATA_W-1:0] alu_res;
  logic              alu_wr, alu_cbw, alu_cbv, start_mul;

  logic [DATA_W-1:0] mcand_q, mplier_q, acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] mdst_q;
  logic [DATA_W-1:0] step_term, acc_next;
  logic              mul_done;

  // Read addresses go straight through to the file's combinational ports.
  assign rs_addr_o = rs_addr_i;
  assign rt_addr_o = rt_addr_i;

  // The write-back stage holds a result the file has not committed yet.
  assign rs_eff = (write_o && write_addr_o == rs_addr_i) ? write_data_o : rs_data_i;
  assign rt_eff = (write_o && write_addr_o == rt_addr_i) ? write_data_o : rt_data_i;
  assign cb_eff = write_CB_o ? cb_data_o : cb_data_i;

  // A predicated instruction whose CB is clear is accepted but has no effect.
  assign accept = valid_i && ready_o;
  assign exec   = accept && !(cond_i && !cb_eff);

  // One shift-add step: add the multiplicand shifted by the current bit index.
  assign step_term = mplier_q[cnt_q] ? (mcand_q << cnt_q) : '0;
  assign acc_next  = acc_q + step_term;
  assign mul_done  = (state_q == S_BUSY) && (cnt_q == CNT_W'(DATA_W - 1));

  // Decode the opcode and compute the single-cycle result.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    alu_res   = '0;
    alu_wr    = 1'b0;
    alu_cbw   = 1'b0;
    alu_cbv   = 1'b0;
    start_mul = 1'b0;
    case (op_i)
      OP_ADD: begin alu_res = rs_eff + rt_eff;         alu_wr = 1'b1; end
      OP_SUB: begin alu_res = rs_eff - rt_eff;         alu_wr = 1'b1; end
      OP_AND: begin alu_res = rs_eff & rt_eff;         alu_wr = 1'b1; end
      OP_OR:  begin alu_res = rs_eff | rt_eff;         alu_wr = 1'b1; end
      OP_XOR: begin alu_res = rs_eff ^ rt_eff;         alu_wr = 1'b1; end
      OP_SHL: begin alu_res = rs_eff << rt_eff[2:0];   alu_wr = 1'b1; end
      OP_SHR: begin alu_res = rs_eff >> rt_eff[2:0];   alu_wr = 1'b1; end
      OP_MOV: begin alu_res = rs_eff;                  alu_wr = 1'b1; end
      OP_LDI: begin alu_res = imm_i;                   alu_wr = 1'b1; end
      OP_SEQ: begin alu_cbv = (rs_eff == rt_eff);      alu_cbw = 1'b1; end
      OP_SLT: begin alu_cbv = (rs_eff < rt_eff);       alu_cbw = 1'b1; end
      OP_MUL: start_mul = 1'b1;
      default: ;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FSM next state: a live MUL enters BUSY, the last step returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (exec && start_mul) state_d = S_BUSY;
      S_BUSY: if (mul_done)          state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: new instructions are taken only while idle.
  always_comb begin
    ready_o = (state_q == S_IDLE);
  end

  // Multiplier operands, partial product and step counter.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      mdst_q   <= '0;
    end else if (state_q == S_IDLE) begin
      if (exec && start_mul) begin
        mcand_q  <= rs_eff;
        mplier_q <= rt_eff;
        acc_q    <= '0;
        cnt_q    <= '0;
        mdst_q   <= dst_addr_i;
      end
    end else begin
      acc_q <= acc_next;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Write-back stage: enables pulse for one cycle per writing instruction.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      write_o      <= 1'b0;
      write_addr_o <= '0;
      write_data_o <= '0;
      write_CB_o   <= 1'b0;
      cb_data_o    <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults followed by conditional overrides; the last assignment wins and every read sees the pre-edge value.
      write_o    <= 1'b0;
      write_CB_o <= 1'b0;
      if (mul_done) begin
        write_o      <= 1'b1;
        write_addr_o <= mdst_q;
        write_data_o <= acc_next;
      end else if (exec && alu_wr) begin
        write_o      <= 1'b1;
        write_addr_o <= dst_addr_i;
        write_data_o <= alu_res;
      end else if (exec && alu_cbw) begin
        write_CB_o <= 1'b1;
        cb_data_o  <= alu_cbv;
      end
    end
  end

endmodule
